onchip_mem_stream_reader: RTL and testbench
===========================================

// Module: onchip_mem_stream_reader
// PURPOSE
//  Avalon-MM read master feeding the 1024x32 single-port on-chip RAM (address registered
//  inside RAM, readdata unregistered -> 1-cycle read latency). On a start pulse, reads
//  word_count words from base_addr. Emits them as an Avalon-ST packet (sop/eop) with
//  backpressure, via an internal FIFO. Sits directly upstream of the RAM's s1 port.
// PARAMETERS
//  ADDR_W      10  RAM word-address width; address space 2**ADDR_W words
//  DATA_W      32  RAM/stream data width
//  FIFO_DEPTH  4   output FIFO entries; power of 2, >=2
// PORTS
//  clk          in   1         system clock
//  reset        in   1         asynchronous, active-high reset
//  start        in   1         1-cycle request; sampled only in IDLE
//  base_addr    in   ADDR_W    first word address, latched on accepted start
//  word_count   in   ADDR_W+1  words to transfer, 0..2**ADDR_W
//  busy         out  1         high from accepted start until done
//  done         out  1         1-cycle pulse after eop beat accepted (or zero-length)
//  m_address    out  ADDR_W    RAM address
//  m_chipselect out  1         RAM chipselect (high while issuing)
//  m_write      out  1         tied 0
//  m_clken      out  1         RAM clken; high only on a read-issue cycle
//  m_readdata   in   DATA_W    RAM readdata, valid the cycle after the issue cycle
//  src_valid    out  1         stream word valid
//  src_ready    in   1         stream sink ready; beat transfers when valid&ready
//  src_data     out  DATA_W    stream word
//  src_sop      out  1         first word of packet
//  src_eop      out  1         last word of packet
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, m_address=0, m_chipselect=0, m_clken=0, src_valid=0,
//   src_sop=0, src_eop=0, FIFO empty, counters 0. Reset mid-transfer aborts; no done pulse.
//  FSM: IDLE -start&count>0-> READ; IDLE -start&count==0-> DONE (no beats).
//   READ -last read issued-> DRAIN; DRAIN -eop beat accepted-> DONE; DONE -> IDLE.
//   done=1 exactly in DONE. start outside IDLE is ignored.
//  Issue rule (READ): issue when remaining>0 and fifo_count+inflight < FIFO_DEPTH.
//   Issue cycle: m_chipselect=1, m_clken=1, m_address=current address. inflight <= 1.
//  Capture: m_readdata is pushed into FIFO on the cycle after issue, with sop/eop tags.
//  Latency: start at cycle 0 -> first issue in cycle 1 -> push in cycle 2 -> src_valid in
//   cycle 3. Sustained throughput is 1 word/cycle while src_ready=1.
//  Address: increments modulo 2**ADDR_W; base=1023, count=3 reads 1023, 0, 1.
//  word_count=2**ADDR_W reads every word once. sop and eop are both set on a 1-word packet.
//  Backpressure: src_data/sop/eop are held stable while src_valid & !src_ready.
//   The FIFO never overflows. A full FIFO with an in-flight word cannot occur.
//  Simultaneous push and pop on a full or empty FIFO is legal; the count is unchanged.
// CONFIGURATION
//  ONCHIP_READER_CHECKSUM_EN defined: adds output checksum[DATA_W-1:0]. It holds the
//   mod-2**DATA_W sum of all accepted beats. It clears on accepted start and holds after
//   done. Reset value is 0.
//  ONCHIP_READER_CHECKSUM_EN undefined: no checksum port or logic; all else identical.
// STRUCTURE
//  Package onchip_reader_pkg: state enum (IDLE, READ, DRAIN, DONE), ADDR_W/DATA_W defaults,
//   FIFO entry struct {data, sop, eop}.
//  Sub-module onchip_rd_fifo: synchronous FIFO (FIFO_DEPTH x DATA_W+2) with push/pop,
//   count, full/empty, and async active-high reset.
// TESTING (bench uses 1024x32 RAM model with 1-cycle registered-address read)
//  RAM[i]=i*3, base=0, count=8, src_ready=1 -> beats 0,3,...,21; sop on 1st beat, eop on
//   8th; src_valid first in cycle 3; done 1 cycle after eop.
//  base=1022, count=4 -> m_address 1022,1023,0,1; data in that order.
//  count=1 -> single beat with sop=eop=1. count=0 -> no beats; done at cycle 1; busy 1 cycle.
//  count=16, src_ready random 50% -> all 16 words in order with no loss or duplication;
//   stable data while stalled; issue suppressed when FIFO full.
//  Assert reset mid-transfer (after 5 beats) -> all outputs reset values, no done.
//   A new start after reset runs a clean packet.
//  ONCHIP_READER_CHECKSUM_EN build, RAM[i]=i, count=1024 -> checksum=0x0007FE00.
//   start pulsed while busy -> ignored.

Source files
------------

// File: rtl/onchip_reader_pkg.sv
// Shared types and default sizes for the on-chip memory stream reader.
package onchip_reader_pkg;

    localparam int ADDR_W_DEF     = 10;
    localparam int DATA_W_DEF     = 32;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    // One FIFO slot: a captured RAM word plus its packet framing tags.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic                  sop;
        logic                  eop;
    } rd_entry_t;

endpackage

// File: rtl/onchip_rd_fifo.sv
// Synchronous FIFO between the RAM capture stage and the Avalon-ST source.
// A push and a pop in the same cycle leave the count unchanged, whether the
// FIFO is full (the freed slot is refilled) or empty (the word passes through).
module onchip_rd_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 34,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_push  = push && (!full || pop);
    assign do_pop   = pop && (!empty || push);
    assign pop_data = empty ? push_data : mem[rd_ptr];

    // Storage write; slot contents only matter once the pointers say so.
    // NOTE: the storage array has no reset; pointers and count define validity, so stale words are never read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; power-of-2 depth lets pointers wrap freely.
    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM read master for a 1-cycle-latency on-chip RAM, streaming the words
// out as one Avalon-ST packet through a small FIFO.
// Optional build macro ONCHIP_READER_CHECKSUM_EN adds a running checksum of
// all accepted beats. The FIFO entry layout comes from the package, so DATA_W
// is expected to match DATA_W_DEF.
module onchip_mem_stream_reader
    import onchip_reader_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic              m_clken,
    input  logic [DATA_W-1:0] m_readdata,
    output logic              src_valid,
    input  logic              src_ready,
    output logic [DATA_W-1:0] src_data,
    output logic              src_sop,
    output logic              src_eop
`ifdef ONCHIP_READER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int             CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W:0] REM_ONE = (ADDR_W + 1)'(1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic              first_pending;
    logic              inflight;
    logic              inflight_sop;
    logic              inflight_eop;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W:0]    occupancy;
    logic              start_ok;
    logic              issue;
    logic              beat;
    rd_entry_t         push_entry;
    rd_entry_t         pop_entry;

    assign start_ok  = (state == IDLE) && start;
    assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(inflight);
    assign issue     = (state == READ) && (remaining != '0) && !fifo_full
                       && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    assign beat      = src_valid && src_ready;

    assign m_address    = addr;
    assign m_chipselect = issue;
    assign m_clken      = issue;
    assign m_write      = 1'b0;

    assign push_entry = '{data: m_readdata, sop: inflight_sop, eop: inflight_eop};
    assign src_valid  = !fifo_empty;
    assign src_data   = pop_entry.data;
    assign src_sop    = pop_entry.sop && !fifo_empty;
    assign src_eop    = pop_entry.eop && !fifo_empty;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and status outputs.
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            IDLE:    if (start) state_nxt = (word_count == '0) ? DONE : READ;
            READ:    if (issue && (remaining == REM_ONE)) state_nxt = DRAIN;
            DRAIN:   if (beat && src_eop) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read issue bookkeeping and tags for the word returning next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr          <= '0;
            remaining     <= '0;
            first_pending <= 1'b0;
            inflight      <= 1'b0;
            inflight_sop  <= 1'b0;
            inflight_eop  <= 1'b0;
        end else begin
            if (start_ok) begin
                addr          <= base_addr;
                remaining     <= word_count;
                first_pending <= 1'b1;
            end else if (issue) begin
                addr          <= addr + 1'b1;
                remaining     <= remaining - 1'b1;
                first_pending <= 1'b0;
            end
            inflight     <= issue;
            inflight_sop <= issue && first_pending;
            inflight_eop <= issue && (remaining == REM_ONE);
        end
    end

    onchip_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(rd_entry_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (push_entry),
        .pop       (beat),
        .pop_data  (pop_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef ONCHIP_READER_CHECKSUM_EN
    // Running sum of accepted beats, cleared when a new transfer is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         checksum <= '0;
        else if (start_ok) checksum <= '0;
        else if (beat)     checksum <= checksum + src_data;
    end
`endif

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Directed bench for onchip_mem_stream_reader with a 1024x32 RAM model that
// registers its address on clken and returns data the following cycle.
module tb_onchip_mem_stream_reader;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int RAM_WORDS  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] m_address;
    logic              m_chipselect;
    logic              m_write;
    logic              m_clken;
    logic [DATA_W-1:0] m_readdata;
    logic              src_valid;
    logic              src_ready;
    logic [DATA_W-1:0] src_data;
    logic              src_sop;
    logic              src_eop;
`ifdef ONCHIP_READER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    logic [DATA_W-1:0] ram [RAM_WORDS];
    logic [ADDR_W-1:0] ram_addr_q = '0;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // RAM model: address registered on clken, readdata unregistered.
    always @(posedge clk) begin
        if (m_clken && m_chipselect && !m_write) ram_addr_q <= m_address;
    end
    assign m_readdata = ram[ram_addr_q];

    onchip_mem_stream_reader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .word_count   (word_count),
        .busy         (busy),
        .done         (done),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write      (m_write),
        .m_clken      (m_clken),
        .m_readdata   (m_readdata),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .src_data     (src_data),
        .src_sop      (src_sop),
        .src_eop      (src_eop)
`ifdef ONCHIP_READER_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},   32'(busy),         0);
        check({tag, "_done"},   32'(done),         0);
        check({tag, "_addr"},   32'(m_address),    0);
        check({tag, "_cs"},     32'(m_chipselect), 0);
        check({tag, "_clken"},  32'(m_clken),      0);
        check({tag, "_write"},  32'(m_write),      0);
        check({tag, "_valid"},  32'(src_valid),    0);
        check({tag, "_sop"},    32'(src_sop),      0);
        check({tag, "_eop"},    32'(src_eop),      0);
    endtask

    // Starts a packet in the current cycle (cycle 0) and follows it to done.
    // Every visible beat is compared with the model word at its packet index,
    // which also proves the head is held while the sink stalls.
    task automatic run_packet(input int base, input int count, input bit rand_ready,
                              input bit glitch, output int first_valid,
                              output int done_cyc, output int busy_cyc, output int beats);
        int issued;
        int bound;
        bit fin;
        issued      = 0;
        beats       = 0;
        first_valid = -1;
        done_cyc    = -1;
        busy_cyc    = 0;
        fin         = 1'b0;
        bound       = 4 * count + 40;
        start       = 1'b1;
        base_addr   = ADDR_W'(base);
        word_count  = (ADDR_W + 1)'(count);
        for (int cyc = 1; cyc <= bound && !fin; cyc++) begin
            @(posedge clk);
            #1;
            start = glitch && (cyc == 2);
            if (glitch) begin
                base_addr  = ADDR_W'(500);
                word_count = (ADDR_W + 1)'(1);
            end
            src_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (busy) busy_cyc++;
            if (m_clken) begin
                check("issue_room", 32'((issued - beats) < FIFO_DEPTH), 1);
                check("issue_addr", 32'(m_address), 32'((base + issued) % RAM_WORDS));
                issued++;
            end
            if (src_valid) begin
                if (first_valid < 0) first_valid = cyc;
                check("beat_data", src_data, ram[(base + beats) % RAM_WORDS]);
                check("beat_sop",  32'(src_sop), 32'(beats == 0));
                check("beat_eop",  32'(src_eop), 32'(beats == count - 1));
                if (src_ready) beats++;
            end
            if (done) begin
                done_cyc = cyc;
                fin      = 1'b1;
            end
        end
        start     = 1'b0;
        src_ready = 1'b1;
        check("done_seen",   32'(fin),    1);
        check("beat_count",  32'(beats),  32'(count));
        check("issue_count", 32'(issued), 32'(count));
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 0);
        check("busy_released",  32'(busy), 0);
    endtask

    initial begin
        int fv;
        int dc;
        int bc;
        int nb;
        bit done_after_abort;

        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        src_ready  = 1'b1;
        for (int i = 0; i < RAM_WORDS; i++) ram[i] = DATA_W'(i * 3);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs("idle");

        // base 0, count 8, sink always ready: beats 0,3,..,21; valid at cycle 3, done at 11.
        run_packet(0, 8, 1'b0, 1'b0, fv, dc, bc, nb);
        check("p8_first_valid", 32'(fv), 3);
        check("p8_done_cycle",  32'(dc), 11);
        check("p8_busy_cycles", 32'(bc), 11);

        // Address wraps: 1022, 1023, 0, 1.
        run_packet(1022, 4, 1'b0, 1'b0, fv, dc, bc, nb);
        check("wrap_done_cycle", 32'(dc), 7);

        // Single-word packet carries sop and eop together.
        run_packet(7, 1, 1'b0, 1'b0, fv, dc, bc, nb);
        check("one_first_valid", 32'(fv), 3);

        // Zero-length: no beats, done in cycle 1, busy for one cycle.
        run_packet(0, 0, 1'b0, 1'b0, fv, dc, bc, nb);
        check("zero_done_cycle",  32'(dc), 1);
        check("zero_busy_cycles", 32'(bc), 1);
        check("zero_no_valid",    32'(fv), 32'(-1));

        // Random backpressure over 16 words.
        run_packet(40, 16, 1'b1, 1'b0, fv, dc, bc, nb);

        // A start pulse while busy must not disturb the running packet.
        run_packet(10, 4, 1'b0, 1'b1, fv, dc, bc, nb);
        check("glitch_done_cycle", 32'(dc), 7);

        // Reset in the middle of a 16-word packet after 5 accepted beats.
        nb         = 0;
        start      = 1'b1;
        base_addr  = ADDR_W'(200);
        word_count = (ADDR_W + 1)'(16);
        for (int cyc = 1; cyc <= 40 && nb < 5; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            #1;
            if (src_valid && src_ready) nb++;
        end
        check("abort_beats_seen", 32'(nb), 5);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("abort");
        #2;
        reset            = 1'b0;
        done_after_abort = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk);
            #1;
            if (done || src_valid || busy) done_after_abort = 1'b1;
        end
        check("abort_quiet", 32'(done_after_abort), 0);

        // Clean packet after the abort.
        run_packet(5, 3, 1'b0, 1'b0, fv, dc, bc, nb);
        check("post_abort_done_cycle", 32'(dc), 6);

        // Full address space, RAM[i] = i.
        for (int i = 0; i < RAM_WORDS; i++) ram[i] = DATA_W'(i);
        run_packet(0, RAM_WORDS, 1'b0, 1'b0, fv, dc, bc, nb);
        check("full_done_cycle", 32'(dc), 32'(RAM_WORDS + 3));
`ifdef ONCHIP_READER_CHECKSUM_EN
        check("checksum_full", checksum, 32'h0007_FE00);
        @(posedge clk);
        #1;
        check("checksum_hold", checksum, 32'h0007_FE00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
